// File: rtl/op_scheduler_pkg.sv
// Shared definitions for the shunting-yard operator scheduler: token codes,
// stack sizing, FSM states and operator classification helpers.
package op_scheduler_pkg;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = $clog2(DEPTH + 1);
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned CO_N  = 4;

    localparam logic [CO_N-1:0] CO_OK = 4'd0;
    localparam logic [CO_N-1:0] CO_LP = 4'd1;
    localparam logic [CO_N-1:0] CO_RP = 4'd2;
    localparam logic [CO_N-1:0] CO_AD = 4'd3;
    localparam logic [CO_N-1:0] CO_SB = 4'd4;
    localparam logic [CO_N-1:0] CO_MU = 4'd5;
    localparam logic [CO_N-1:0] CO_DI = 4'd6;
    localparam logic [CO_N-1:0] CO_PS = 4'd7;
    localparam logic [CO_N-1:0] CO_NS = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RED  = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    // Binding strength; 0 marks tokens that never reduce (LP, OK, empty stack).
    function automatic logic [1:0] op_level(input logic [CO_N-1:0] op);
        case (op)
            CO_PS, CO_NS: op_level = 2'd3;
            CO_MU, CO_DI: op_level = 2'd2;
            CO_AD, CO_SB: op_level = 2'd1;
            default:      op_level = 2'd0;
        endcase
    endfunction

    function automatic logic is_binary(input logic [CO_N-1:0] op);
        is_binary = (op == CO_AD) || (op == CO_SB) || (op == CO_MU) || (op == CO_DI);
    endfunction

    function automatic logic is_opener(input logic [CO_N-1:0] op);
        is_opener = (op == CO_LP) || (op == CO_PS) || (op == CO_NS);
    endfunction

endpackage

// File: rtl/op_scheduler_prec.sv
// Precedence comparator: prec_o=1 when the stack top (b_i) must be reduced
// before the pending token (a_i); equal levels reduce, giving left associativity.
module op_scheduler_prec
    import op_scheduler_pkg::*;
(
    input  logic [CO_N-1:0] a_i,
    input  logic [CO_N-1:0] b_i,
    output logic            prec_o
);

    logic [1:0] lvl_a;
    logic [1:0] lvl_b;

    assign lvl_a  = op_level(a_i);
    assign lvl_b  = op_level(b_i);
    assign prec_o = (lvl_b != 2'd0) && (lvl_b >= lvl_a);

endmodule

// File: rtl/op_scheduler.sv
// Operator-stack scheduler for the calculator CPU: pushes tokens or issues the
// stack top to the evaluator as reduce requests, flagging done and errors.
module op_scheduler
    import op_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [CO_N-1:0] in_op,
    output logic            in_ready,
    output logic            red_valid,
    output logic [CO_N-1:0] red_op,
    input  logic            red_ready,
    output logic            done,
    output logic            err,
    output logic [AW-1:0]   depth
);

    state_e          state_q, state_d;
    logic [CO_N-1:0] pend_q, pend_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            done_q, done_d;
    logic [CO_N-1:0] stack_q [DEPTH];
    logic            push, pop;
    logic            empty, full, prec;
    logic [CO_N-1:0] top;

    assign empty = (ptr_q == '0);
    assign full  = (ptr_q == AW'(DEPTH));
    assign top   = empty ? CO_OK : stack_q[IW'(ptr_q - AW'(1))];

    op_scheduler_prec u_prec (
        .a_i    (pend_q),
        .b_i    (top),
        .prec_o (prec)
    );

    // Next-state, stack control and done pulse
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pend_d  = in_op;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d = S_IDLE;
                if (is_opener(pend_q) ||
                    (is_binary(pend_q) && (empty || top == CO_LP || !prec))) begin
                    if (full) state_d = S_ERR;
                    else      push    = 1'b1;
                end else if (is_binary(pend_q)) begin
                    state_d = S_RED;
                end else if (pend_q == CO_RP) begin
                    if (empty)              state_d = S_ERR;
                    else if (top == CO_LP)  pop     = 1'b1;
                    else                    state_d = S_RED;
                end else if (pend_q == CO_OK) begin
                    if (empty)              done_d  = 1'b1;
                    else if (top == CO_LP)  state_d = S_ERR;
                    else                    state_d = S_RED;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_RED: begin
                if (red_ready) begin
                    pop     = 1'b1;
                    state_d = S_EVAL;
                end
            end
            default: ;
        endcase
        // clr overrides acceptance, reduce handshakes and error hold
        if (clr) begin
            state_d = S_IDLE;
            pend_d  = CO_OK;
            done_d  = 1'b0;
            push    = 1'b0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (clr)       ptr_d = '0;
        else if (push) ptr_d = ptr_q + AW'(1);
        else if (pop)  ptr_d = ptr_q - AW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= CO_OK;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Stack storage carries no reset; only entries below ptr_q are ever read
    always_ff @(posedge clk) begin
        if (push) stack_q[IW'(ptr_q)] <= pend_q;
    end

    assign in_ready  = (state_q == S_IDLE) && !clr;
    assign red_valid = (state_q == S_RED);
    assign red_op    = red_valid ? top : CO_OK;
    assign err       = (state_q == S_ERR);
    assign done      = done_q;
    assign depth     = ptr_q;

endmodule

// File: tb/tb_op_scheduler.sv
// Self-checking bench for op_scheduler: directed expression scenarios plus
// random token streams checked against a queue-based shunting-yard model.
module tb_op_scheduler;
    import op_scheduler_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clr = 1'b0;
    logic            in_valid = 1'b0;
    logic [CO_N-1:0] in_op = CO_OK;
    logic            in_ready;
    logic            red_valid;
    logic [CO_N-1:0] red_op;
    logic            red_ready = 1'b0;
    logic            done;
    logic            err;
    logic [AW-1:0]   depth;

    int n_checks = 0;
    int n_errors = 0;

    logic [CO_N-1:0] mstack[$];
    logic [CO_N-1:0] exp_red[$];
    logic [CO_N-1:0] red_log[$];
    logic [CO_N-1:0] want_q[$];
    bit              exp_err;
    bit              exp_done;
    int              stall_left = 0;

    op_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_ready  (in_ready),
        .red_valid (red_valid),
        .red_op    (red_op),
        .red_ready (red_ready),
        .done      (done),
        .err       (err),
        .depth     (depth)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int rank(input logic [CO_N-1:0] op);
        if (op == CO_PS || op == CO_NS) return 3;
        if (op == CO_MU || op == CO_DI) return 2;
        if (op == CO_AD || op == CO_SB) return 1;
        return 0;
    endfunction

    // Reference: classic shunting-yard on a queue, emitting expected reduce ops
    task automatic model_token(input logic [CO_N-1:0] op);
        exp_done = 1'b0;
        if (op == CO_LP || op == CO_PS || op == CO_NS) begin
            if (mstack.size() == DEPTH) exp_err = 1'b1;
            else mstack.push_back(op);
        end else if (rank(op) == 1 || rank(op) == 2) begin
            while (mstack.size() > 0 && mstack[$] != CO_LP && rank(mstack[$]) >= rank(op))
                exp_red.push_back(mstack.pop_back());
            if (mstack.size() == DEPTH) exp_err = 1'b1;
            else mstack.push_back(op);
        end else if (op == CO_RP) begin
            while (mstack.size() > 0 && mstack[$] != CO_LP)
                exp_red.push_back(mstack.pop_back());
            if (mstack.size() == 0) exp_err = 1'b1;
            else void'(mstack.pop_back());
        end else begin
            while (mstack.size() > 0 && mstack[$] != CO_LP)
                exp_red.push_back(mstack.pop_back());
            if (mstack.size() == 0) exp_done = 1'b1;
            else exp_err = 1'b1;
        end
    endtask

    task automatic model_clear();
        mstack.delete();
        exp_red.delete();
        exp_err  = 1'b0;
        exp_done = 1'b0;
    endtask

    // Present one token and serve reduce requests until the scheduler settles
    task automatic send_tok(input logic [CO_N-1:0] op);
        int cyc = 0;
        @(negedge clk);
        check_eq("in_ready_pre", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_op    = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_token(op);
        check_eq("busy_after_accept", 32'(in_ready), 32'(0));
        forever begin
            @(negedge clk);
            if (red_valid) begin
                check_eq("red_with_done", 32'(done), 32'(0));
                if (exp_red.size() == 0) begin
                    check_eq("spurious_red", 32'(red_valid), 32'(0));
                    red_ready = 1'b1;
                end else if (stall_left > 0) begin
                    red_ready = 1'b0;
                    stall_left--;
                    check_eq("stall_red_op", 32'(red_op), 32'(exp_red[0]));
                    check_eq("stall_in_ready", 32'(in_ready), 32'(0));
                end else begin
                    red_ready = ($urandom_range(0, 3) != 0);
                    if (red_ready) begin
                        check_eq("red_op", 32'(red_op), 32'(exp_red.pop_front()));
                        red_log.push_back(red_op);
                    end
                end
            end else begin
                red_ready = 1'b0;
            end
            if (in_ready || err) break;
            cyc++;
            if (cyc > 200) begin
                check_eq("settle_timeout", 32'(cyc), 32'(0));
                break;
            end
        end
        red_ready = 1'b0;
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("err", 32'(err), 32'(exp_err));
        check_eq("depth", 32'(depth), 32'(mstack.size()));
        check_eq("reduces_left", 32'(exp_red.size()), 32'(0));
        exp_red.delete();
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        #1;
        check_eq("clr_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        #1;
        check_eq("clr_err", 32'(err), 32'(0));
        check_eq("clr_depth", 32'(depth), 32'(0));
        check_eq("clr_in_ready_after", 32'(in_ready), 32'(1));
    endtask

    task automatic expect_log(input string tag);
        check_eq({tag, "_len"}, 32'(red_log.size()), 32'(want_q.size()));
        for (int i = 0; i < want_q.size() && i < red_log.size(); i++)
            check_eq(tag, 32'(red_log[i]), 32'(want_q[i]));
        red_log.delete();
    endtask

    initial begin
        logic [CO_N-1:0] toks [9];
        int wait_cyc;
        toks = '{CO_OK, CO_LP, CO_RP, CO_AD, CO_SB, CO_MU, CO_DI, CO_PS, CO_NS};
        model_clear();

        #12;
        check_eq("rst_red_valid", 32'(red_valid), 32'(0));
        check_eq("rst_err", 32'(err), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'(1));
        check_eq("rst_red_op", 32'(red_op), 32'(CO_OK));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_depth", 32'(depth), 32'(0));

        // precedence: higher binds first
        send_tok(CO_AD); send_tok(CO_MU); send_tok(CO_OK);
        want_q = {CO_MU, CO_AD}; expect_log("t1_seq");

        // left associativity
        send_tok(CO_AD); send_tok(CO_SB); send_tok(CO_OK);
        want_q = {CO_AD, CO_SB}; expect_log("t2_seq");

        // parentheses never produce requests
        send_tok(CO_MU); send_tok(CO_LP); send_tok(CO_AD); send_tok(CO_RP); send_tok(CO_OK);
        want_q = {CO_AD, CO_MU}; expect_log("t3_seq");

        // unary signs bind tightest
        send_tok(CO_NS); send_tok(CO_NS);
        check_eq("t4_depth", 32'(depth), 32'(2));
        send_tok(CO_AD); send_tok(CO_OK);
        want_q = {CO_NS, CO_NS, CO_AD}; expect_log("t4_seq");

        // overflow on DEPTH+1 opens
        for (int i = 0; i <= DEPTH; i++) send_tok(CO_LP);
        check_eq("t5_err", 32'(err), 32'(1));
        check_eq("t5_depth", 32'(depth), 32'(DEPTH));
        check_eq("t5_in_ready", 32'(in_ready), 32'(0));
        do_clr();
        red_log.delete();

        // backpressure holds the request stable
        send_tok(CO_AD); send_tok(CO_MU);
        stall_left = 5;
        send_tok(CO_OK);
        check_eq("t6_stall_used", 32'(stall_left), 32'(0));
        want_q = {CO_MU, CO_AD}; expect_log("t6_seq");

        // close with nothing open
        send_tok(CO_RP);
        check_eq("t7_err", 32'(err), 32'(1));
        do_clr();

        // async reset while a request is outstanding
        send_tok(CO_AD); send_tok(CO_MU);
        @(negedge clk);
        in_valid = 1'b1; in_op = CO_OK;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_cyc = 0;
        while (!red_valid && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_eq("t7_red_seen", 32'(red_valid), 32'(1));
        #2 rst = 1'b1;
        #1;
        check_eq("t7_rst_red_valid", 32'(red_valid), 32'(0));
        check_eq("t7_rst_red_op", 32'(red_op), 32'(CO_OK));
        check_eq("t7_rst_depth", 32'(depth), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        red_log.delete();

        // random token streams
        for (int n = 0; n < 400; n++) begin
            if (exp_err) do_clr();
            send_tok(toks[$urandom_range(0, 8)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
